imem_loader: RTL and testbench

//   Writer side of the instruction memory. Receives a framed byte stream
//   (UART receiver output, valid/ready) and writes big-endian 32-bit words

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame marker default
// and loader state encoding.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory writer: parses a framed byte stream into big-endian 32-bit
// words, writes them at consecutive word addresses and holds the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 30,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [7:0]            SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_din,
    output logic                  cpu_rst_hold,
    output logic                  done,
    output logic                  error
);

    state_t      state, state_nxt;
    logic        xfer;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  lane;
    logic [7:0]  chk;
    logic [23:0] asm_p0;
    logic        last_word;

    assign in_ready  = ~rst;
    assign xfer      = in_valid & in_ready;
    assign last_word = (word_cnt == len - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            case (state)
                ST_IDLE:   if (in_data == SYNC_BYTE) state_nxt = ST_LEN_HI;
                ST_LEN_HI: state_nxt = ST_LEN_LO;
                ST_LEN_LO: state_nxt = ({len[15:8], in_data} != 16'd0) ? ST_DATA : ST_CHK;
                ST_DATA:   if (lane == 2'd3 && last_word) state_nxt = ST_CHK;
                ST_CHK:    state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Byte assembly: upper three bytes of the word in flight, not reset.
    always_ff @(posedge clk) begin
        if (xfer && state == ST_DATA) asm_p0 <= {asm_p0[15:0], in_data};
    end

    // Write stage: strobe, address and data become visible one cycle after the
    // word's last byte; a strobe pending at reset is simply cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_din     <= 32'd0;
            cpu_rst_hold <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            len          <= 16'd0;
            word_cnt     <= 16'd0;
            lane         <= 2'd0;
            chk          <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    ST_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            done         <= 1'b0;
                            error        <= 1'b0;
                            cpu_rst_hold <= 1'b1;
                            word_cnt     <= 16'd0;
                            lane         <= 2'd0;
                            chk          <= 8'd0;
                        end
                    end
                    ST_LEN_HI: len[15:8] <= in_data;
                    ST_LEN_LO: len[7:0]  <= in_data;
                    ST_DATA: begin
                        chk  <= chk ^ in_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_din  <= {asm_p0, in_data};
                            imem_addr <= BASE_ADDR + ADDR_WIDTH'(word_cnt);
                            word_cnt  <= word_cnt + 16'd1;
                        end
                    end
                    ST_CHK: begin
                        cpu_rst_hold <= 1'b0;
                        if (in_data == chk) done  <= 1'b1;
                        else                error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0x3FFFFFFF) share one
// byte stream; writes are scoreboarded against a frame-level reference model.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];
    localparam logic [29:0] WBASE = 30'h3FFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        rdy0, we0, hold0, done0, err0;
    logic [29:0] addr0;
    logic [31:0] din0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [29:0] addr1;
    logic [31:0] din1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [61:0] exp_q0[$];
    logic [61:0] exp_qw[$];
    logic        exp_done, exp_err;

    always #5 clk = ~clk;

    imem_loader dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
        .imem_we(we0), .imem_addr(addr0), .imem_din(din0),
        .cpu_rst_hold(hold0), .done(done0), .error(err0)
    );

    imem_loader #(.BASE_ADDR(WBASE)) dut_w (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
        .imem_we(we1), .imem_addr(addr1), .imem_din(din1),
        .cpu_rst_hold(hold1), .done(done1), .error(err1)
    );

    // Write scoreboard: every strobe must match the next expected write.
    always @(negedge clk) begin
        logic [61:0] e;
        if (we0) begin
            n_checks++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL write_base0: got addr=%h data=%h, required no write", addr0, din0);
            end else begin
                e = exp_q0.pop_front();
                if ({addr0, din0} !== e) begin
                    n_fail++;
                    $display("FAIL write_base0: got addr=%h data=%h, required addr=%h data=%h",
                             addr0, din0, e[61:32], e[31:0]);
                end
            end
        end
        if (we1) begin
            n_checks++;
            if (exp_qw.size() == 0) begin
                n_fail++;
                $display("FAIL write_basew: got addr=%h data=%h, required no write", addr1, din1);
            end else begin
                e = exp_qw.pop_front();
                if ({addr1, din1} !== e) begin
                    n_fail++;
                    $display("FAIL write_basew: got addr=%h data=%h, required addr=%h data=%h",
                             addr1, din1, e[61:32], e[31:0]);
                end
            end
        end
    end

    // Frame-level model: scan for marker, read length, words, checksum.
    task automatic model(input bq_t s);
        int i = 0;
        int n;
        logic [7:0]  x;
        logic [31:0] word;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            n = int'({s[i+1], s[i+2]});
            i += 3;
            x = 8'd0;
            for (int w = 0; w < n; w++) begin
                word = {s[i], s[i+1], s[i+2], s[i+3]};
                x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                i += 4;
                exp_q0.push_back({30'(w), word});
                exp_qw.push_back({WBASE + 30'(w), word});
            end
            exp_done = (s[i] == x);
            exp_err  = ~exp_done;
            i++;
        end
    endtask

    function automatic bq_t make_frame(input int n, input bit corrupt);
        bq_t f;
        logic [7:0] x = 8'd0;
        logic [7:0] b;
        f.push_back(8'hA5);
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        for (int k = 0; k < 4 * n; k++) begin
            b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
            f.push_back(b);
            x ^= b;
        end
        f.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        return f;
    endfunction

    // mode 0: back-to-back, 1: valid toggling every cycle, 2: random gaps
    task automatic send(input bq_t s, input int mode);
        foreach (s[k]) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic bq_t frame1(input logic [7:0] c);
        bq_t f = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h17, 8'h00, 8'h14,
                   8'h3C, 8'h1D, 8'h10, 8'h00};
        f.push_back(c);
        return f;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({we0, addr0, din0, hold0, done0, err0, rdy0} !== {1'b0, 30'h0, 32'h0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_base0: got we=%b addr=%h din=%h hold=%b done=%b err=%b rdy=%b, required all zero",
                     we0, addr0, din0, hold0, done0, err0, rdy0);
        end
        n_checks++;
        if ({we1, addr1, rdy1} !== {1'b0, WBASE, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_basew: got we=%b addr=%h rdy=%b, required 0 %h 0", we1, addr1, rdy1, WBASE);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rdy0, rdy1, hold0, done0, err0} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b%b hold=%b done=%b err=%b, required rdy=11 others 0",
                     rdy0, rdy1, hold0, done0, err0);
        end
    endtask

    task automatic test_frame_ok();
        exp_q0.push_back({30'h0, 32'h24170014});
        exp_q0.push_back({30'h1, 32'h3C1D1000});
        exp_qw.push_back({30'h3FFFFFFF, 32'h24170014});
        exp_qw.push_back({30'h0, 32'h3C1D1000});
        send(frame1(8'h16), 0);
        idle(2);
        n_checks++;
        if (exp_q0.size() != 0 || exp_qw.size() != 0) begin
            n_fail++;
            $display("FAIL frame_ok_writes: got %0d/%0d writes outstanding, required 0", exp_q0.size(), exp_qw.size());
        end
        n_checks++;
        if ({done0, err0, hold0, done1, err1, hold1} !== 6'b100100) begin
            n_fail++;
            $display("FAIL frame_ok_status: got done/err/hold=%b%b%b %b%b%b, required 100 100",
                     done0, err0, hold0, done1, err1, hold1);
        end
    endtask

    task automatic test_bad_chk();
        model(frame1(8'h17));
        send(frame1(8'h17), 0);
        idle(2);
        n_checks++;
        if (exp_q0.size() != 0 || exp_qw.size() != 0) begin
            n_fail++;
            $display("FAIL bad_chk_writes: got %0d/%0d writes outstanding, required 0", exp_q0.size(), exp_qw.size());
        end
        n_checks++;
        if ({done0, err0, hold0} !== {exp_done, exp_err, 1'b0} || {done0, err0} !== 2'b01) begin
            n_fail++;
            $display("FAIL bad_chk_status: got done=%b err=%b hold=%b, required done=0 err=1 hold=0", done0, err0, hold0);
        end
    endtask

    task automatic test_sync_hold();
        bq_t s = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};
        logic [6:0] hold_exp = 7'b0001110;
        foreach (s[k]) begin
            in_valid = 1'b1;
            in_data  = s[k];
            @(negedge clk);
            n_checks++;
            if (hold0 !== hold_exp[6-k]) begin
                n_fail++;
                $display("FAIL sync_hold_byte%0d: got hold=%b, required %b", k, hold0, hold_exp[6-k]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done0, err0, hold0, done1, err1} !== 5'b10010) begin
            n_fail++;
            $display("FAIL sync_hold_status: got done=%b err=%b hold=%b done_w=%b err_w=%b, required 1 0 0 1 0",
                     done0, err0, hold0, done1, err1);
        end
    endtask

    task automatic test_stall();
        model(frame1(8'h16));
        send(frame1(8'h16), 1);
        idle(2);
        n_checks++;
        if (exp_q0.size() != 0 || exp_qw.size() != 0) begin
            n_fail++;
            $display("FAIL stall_writes: got %0d/%0d writes outstanding, required 0", exp_q0.size(), exp_qw.size());
        end
        n_checks++;
        if ({done0, err0, hold0} !== {exp_done, exp_err, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_status: got done=%b err=%b hold=%b, required %b %b 0", done0, err0, hold0, exp_done, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        bq_t f = frame1(8'h16);
        bq_t part;
        for (int k = 0; k < 9; k++) part.push_back(f[k]);
        model(f);
        while (exp_q0.size() > 1) void'(exp_q0.pop_back());
        while (exp_qw.size() > 1) void'(exp_qw.pop_back());
        send(part, 0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({we0, addr0, din0, hold0, done0, err0, rdy0} !== {1'b0, 30'h0, 32'h0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%h din=%h hold=%b done=%b err=%b rdy=%b, required all zero",
                     we0, addr0, din0, hold0, done0, err0, rdy0);
        end
        rst = 1'b0;
        idle(6);
        n_checks++;
        if (exp_q0.size() != 0 || exp_qw.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_first_word: got %0d/%0d writes outstanding, required 0", exp_q0.size(), exp_qw.size());
        end
        model(f);
        send(f, 0);
        idle(2);
        n_checks++;
        if (exp_q0.size() != 0 || exp_qw.size() != 0 || {done0, err0, hold0} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_refill: got outstanding=%0d done=%b err=%b hold=%b, required 0 1 0 0",
                     exp_q0.size(), done0, err0, hold0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            bq_t s;
            bq_t f;
            int  junk = $urandom_range(0, 3);
            int  n    = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
            for (int j = 0; j < junk; j++) s.push_back(8'($urandom_range(0, 8'hA4)));
            f = make_frame(n, $urandom_range(0, 3) == 0);
            foreach (f[k]) s.push_back(f[k]);
            model(s);
            send(s, int'($urandom_range(0, 2)));
            idle(2);
            n_checks++;
            if (exp_q0.size() != 0 || exp_qw.size() != 0) begin
                n_fail++;
                $display("FAIL random%0d_writes: got %0d/%0d writes outstanding, required 0", t, exp_q0.size(), exp_qw.size());
            end
            n_checks++;
            if ({done0, err0, hold0, done1, err1, hold1} !== {exp_done, exp_err, 1'b0, exp_done, exp_err, 1'b0}) begin
                n_fail++;
                $display("FAIL random%0d_status: got %b%b%b %b%b%b, required %b%b0 %b%b0", t,
                         done0, err0, hold0, done1, err1, hold1, exp_done, exp_err, exp_done, exp_err);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_ok();
        test_bad_chk();
        test_sync_hold();
        test_stall();
        test_reset_mid();
        test_random();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
